// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin mux arbiter slice:
// default data width, channel count and FSM state encodings.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NCH   = 4;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

endpackage

// File: rtl/mux4to1.sv
// Plain 4:1 payload multiplexer; combinational, no state.
module mux4to1 #(
  parameter int WIDTH = mux_pkg::DEFAULT_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four requesters feeding a single registered
// output slot with valid/ready handshake towards the consumer.
module rr_mux_arbiter #(
  parameter int WIDTH = mux_pkg::DEFAULT_WIDTH,
  parameter int NCH   = mux_pkg::DEFAULT_NCH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] data4,
  output logic [NCH-1:0]   ack,
  output logic [1:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan
);
  import mux_pkg::*;

  logic [0:0]       state, state_next;
  logic [1:0]       last_q;
  logic [1:0]       select_q;
  logic [1:0]       grant;
  logic             any_req;
  logic             capture;
  logic [WIDTH-1:0] mux_y;

  // Scanning downward lets the nearest set bit after 'last' overwrite the others.
  function automatic logic [1:0] next_grant(input logic [NCH-1:0] r,
                                            input logic [1:0] last);
    logic [1:0] g;
    logic [1:0] idx;
    g = last;
    for (int k = NCH; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) g = idx;
    end
    return g;
  endfunction

  assign any_req   = |req;
  assign grant     = next_grant(req, last_q);
  assign out_valid = (state == FULL);

  // Reset is folded in so select and ack drop the moment rst_n falls.
  always_comb begin
    select  = (rst_n && any_req) ? grant : select_q;
    capture = rst_n && any_req && ((state == EMPTY) || out_ready);
    ack     = capture ? ({{(NCH-1){1'b0}}, 1'b1} << grant) : '0;
  end

  mux4to1 #(.WIDTH(WIDTH)) u_mux (
    .sel (select),
    .d0  (data1),
    .d1  (data2),
    .d2  (data3),
    .d3  (data4),
    .y   (mux_y)
  );

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (capture) state_next = FULL;
      FULL:    if (out_ready && !capture) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      last_q   <= 2'd3;
      select_q <= 2'd0;
      out_data <= '0;
      out_chan <= 2'd0;
    end else begin
      state    <= state_next;
      select_q <= select;
      if (capture) begin
        last_q   <= grant;
        out_data <= mux_y;
        out_chan <= grant;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter: reset, single request,
// full rotation, backpressure, idle drain and wrap-around priority.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] data1, data2, data3, data4;
  logic [3:0]  ack;
  logic [1:0]  select;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_chan;

  int checks;
  int errors;

  rr_mux_arbiter #(.WIDTH(16), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .data4     (data4),
    .ack       (ack),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    #1;
  endtask

  logic [15:0] rot_data [5];
  logic [1:0]  rot_chan [5];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    data1     = 16'd4095;
    data2     = 16'd61455;
    data3     = 16'd12345;
    data4     = 16'd20197;
    rot_data  = '{16'd4095, 16'd61455, 16'd12345, 16'd20197, 16'd4095};
    rot_chan  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid",  32'(out_valid), 32'd0);
    checkOutput("rst_data",   32'(out_data),  32'd0);
    checkOutput("rst_chan",   32'(out_chan),  32'd0);
    checkOutput("rst_ack",    32'(ack),       32'd0);
    checkOutput("rst_select", 32'(select),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request on channel 0
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_ack",      32'(ack),       32'b0001);
    checkOutput("single_pre_vld",  32'(out_valid), 32'd0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_valid",    32'(out_valid), 32'd1);
    checkOutput("single_data",     32'(out_data),  32'd4095);
    checkOutput("single_chan",     32'(out_chan),  32'd0);
    checkOutput("single_ack_off",  32'(ack),       32'd0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_drain",    32'(out_valid), 32'd0);

    // Reset while FULL discards the payload
    applyStimulus(4'b0001, 1'b0);
    checkOutput("rfull_ack",       32'(ack),       32'b0001);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("rfull_valid",     32'(out_valid), 32'd1);
    checkOutput("rfull_data",      32'(out_data),  32'd4095);
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_valid",      32'(out_valid), 32'd0);
    checkOutput("rmid_data",       32'(out_data),  32'd0);
    checkOutput("rmid_select",     32'(select),    32'd0);
    checkOutput("rmid_ack",        32'(ack),       32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'b0000, 1'b1);
      checkOutput("rpost_ack",     32'(ack),       32'd0);
      checkOutput("rpost_valid",   32'(out_valid), 32'd0);
    end

    // Full rotation from fresh priority (last = 3)
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i < 5) ? 4'b1111 : 4'b0000, 1'b1);
      if (i < 5) checkOutput($sformatf("rot_ack%0d", i), 32'(ack), 32'(4'b0001 << (i % 4)));
      else       checkOutput("rot_ack_idle", 32'(ack), 32'd0);
      if (i > 0) begin
        checkOutput($sformatf("rot_data%0d", i - 1), 32'(out_data),  32'(rot_data[i-1]));
        checkOutput($sformatf("rot_chan%0d", i - 1), 32'(out_chan),  32'(rot_chan[i-1]));
        checkOutput($sformatf("rot_vld%0d",  i - 1), 32'(out_valid), 32'd1);
      end
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rot_drain", 32'(out_valid), 32'd0);

    // Backpressure: hold channel 1 payload while channel 2 waits
    applyStimulus(4'b0010, 1'b1);
    checkOutput("bp_ack_load", 32'(ack), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput($sformatf("bp_data%0d", i),  32'(out_data),  32'd61455);
      checkOutput($sformatf("bp_chan%0d", i),  32'(out_chan),  32'd1);
      checkOutput($sformatf("bp_vld%0d", i),   32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_ack%0d", i),   32'(ack),       32'd0);
    end
    applyStimulus(4'b0100, 1'b1);
    checkOutput("bp_release_ack",  32'(ack),      32'b0100);
    checkOutput("bp_release_data", 32'(out_data), 32'd61455);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("bp_next_data",    32'(out_data), 32'd12345);
    checkOutput("bp_next_chan",    32'(out_chan), 32'd2);
    checkOutput("idle_select",     32'(select),   32'd2);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("idle_valid",      32'(out_valid), 32'd0);
    checkOutput("idle_select2",    32'(select),    32'd2);

    // Wrap priority: bring last to 3, then alternate between 1 and 3
    applyStimulus(4'b1000, 1'b1);
    checkOutput("wrap_ack_pre", 32'(ack), 32'b1000);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("wrap_ack0",    32'(ack),    32'b0010);
    checkOutput("wrap_sel0",    32'(select), 32'd1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("wrap_ack1",    32'(ack),    32'b1000);
    checkOutput("wrap_sel1",    32'(select), 32'd3);
    checkOutput("wrap_chan1",   32'(out_chan), 32'd1);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("wrap_ack2",    32'(ack),    32'b0010);
    checkOutput("wrap_chan2",   32'(out_chan), 32'd3);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("wrap_chan3",   32'(out_chan), 32'd1);
    checkOutput("wrap_data3",   32'(out_data), 32'd61455);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of every channel and of the output.
REQ-002 SHALL have parameter NCH, default 4, number of channels; fixed at 4 in this revision.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-channel request; bit i qualifies data(i+1).
REQ-006 SHALL have ports data1, data2, data3, data4  input  WIDTH  channel payloads.
REQ-007 SHALL have port ack  output  4  one-hot pulse; channel whose payload was captured this cycle.
REQ-008 SHALL have port select  output  2  current grant index, drives downstream 4:1 mux select.
REQ-009 SHALL have port out_valid  output  1  output register holds a payload.
REQ-010 SHALL have port out_ready  input  1  consumer accepts payload when out_valid high.
REQ-011 SHALL have port out_data  output  WIDTH  registered payload.
REQ-012 SHALL have port out_chan  output  2  channel index of out_data.

Function
REQ-013 SHALL implement FSM with states EMPTY (out register free) and FULL (out register holds payload).
REQ-014 SHALL compute grant combinationally each cycle: first set req bit searching from (last+1) mod 4 upward with wrap, last = most recently captured channel.
REQ-015 SHALL drive select = grant index whenever any req bit set; select holds previous value when req = 0.
REQ-016 SHALL capture (load) when any req set AND (state EMPTY OR (state FULL AND out_ready)); capture writes out_data = selected payload, out_chan = grant, updates last = grant.
REQ-017 SHALL assert ack[grant] for exactly the capture cycle; ack = 0 otherwise; requester deasserts or presents next payload after ack.
REQ-018 SHALL transition EMPTY->FULL on capture; FULL->EMPTY on out_ready with no capture; FULL->FULL on out_ready with capture (back-to-back, one payload per cycle) or on !out_ready.
REQ-019 SHALL hold out_data, out_chan, out_valid stable while out_valid & !out_ready.
REQ-020 SHALL have latency of exactly 1 cycle from capture edge to out_valid.
REQ-021 SHALL, when req = 4'b1111 continuously with out_ready = 1, grant in order 0,1,2,3,0,... with no channel starved beyond 3 cycles.
REQ-022 SHALL pass payload bits unmodified; no arithmetic, no width change.
REQ-023 SHALL ignore req changes between edges; only values at the rising edge matter.

Reset
REQ-024 SHALL on rst_n low immediately force state EMPTY, out_valid 0, out_data 0, out_chan 0, ack 0, select 0, last = 3 (so channel 0 has first priority).
REQ-025 SHALL on reset mid-transfer discard the held payload; no ack is issued for it afterwards.
REQ-026 SHALL begin arbitration on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place WIDTH default, NCH, and state encodings (EMPTY=0, FULL=1) in shared package mux_pkg.
REQ-028 SHALL instantiate existing mux4to1 as the sole sub-module for payload selection, driven by select.
REQ-029 SHALL keep the grant priority search as a combinational function within this module.

Verification
REQ-030 SHALL cover reset: rst_n low mid-FULL with data1=4095 -> out_valid=0, out_data=0, select=0 immediately, no ack after release.
REQ-031 SHALL cover single request: req=0001, data1=4095, out_ready=1 -> ack=0001 one cycle, next cycle out_valid=1, out_data=4095, out_chan=0.
REQ-032 SHALL cover full rotation: req=1111, data1..4=4095,61455,12345,20197, out_ready=1 -> out_data sequence 4095,61455,12345,20197,4095, out_chan 0,1,2,3,0.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles while FULL with 61455 -> out_data stays 61455, ack=0, then out_ready=1 -> next capture same cycle.
REQ-034 SHALL cover wrap priority: last=3, req=1010 -> grant 1; then req=1010 -> grant 3; then grant 1.
REQ-035 SHALL cover idle drain: FULL, req=0, out_ready=1 -> out_valid=0 next cycle, select unchanged.
